apb_pwm_cfg_sequencer: RTL

APB master-side controller that programs the APB PWM slave register file (PERIOD 0x0, PULSE 0x4, SIZE 0x8, ENABLE 0xC) from a single config request.
- Accepts a request on a valid/ready handshake, then issues a fixed, glitch-safe write sequence.
- Reports completion, or slave error / timeout, to the requester.
- Sits between the system control logic (or CPU-less boot config) and the PWM APB slave.

---
 rtl/apb_pwm_pkg.sv | 41 ++++
 rtl/apb_pwm_cfg_sequencer_if.sv | 23 ++
 rtl/apb_master_xfer.sv | 90 +++++++++
 rtl/apb_pwm_cfg_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pwm_pkg.sv
// Shared constants and types for the APB PWM config sequencer.
// Optional readback verification is enabled by APB_PWM_CFG_READBACK_EN.
package apb_pwm_pkg;

    localparam logic [7:0] OFF_PERIOD = 8'h00;
    localparam logic [7:0] OFF_PULSE  = 8'h04;
    localparam logic [7:0] OFF_SIZE   = 8'h08;
    localparam logic [7:0] OFF_ENABLE = 8'h0C;

    localparam int unsigned NUM_STEPS = 5;

    typedef logic [2:0] step_t;
    localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_SLAVE    = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_READBACK = 2'b11
    } err_code_e;

    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_RUN   = 2'd1;
    localparam logic [1:0] SEQ_DONE  = 2'd2;
    localparam logic [1:0] SEQ_ABORT = 2'd3;

    localparam logic [1:0] XF_IDLE   = 2'd0;
    localparam logic [1:0] XF_SETUP  = 2'd1;
    localparam logic [1:0] XF_ACCESS = 2'd2;

    // Steps 0 and 4 both target ENABLE (disable first, enable last).
    function automatic logic [7:0] step_offset(step_t s);
        case (s)
            3'd1:    return OFF_PERIOD;
            3'd2:    return OFF_PULSE;
            3'd3:    return OFF_SIZE;
            default: return OFF_ENABLE;
        endcase
    endfunction

endpackage

// File: rtl/apb_pwm_cfg_sequencer_if.sv
// APB bus bundle between the config sequencer (master) and the PWM slave.
interface apb_pwm_cfg_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLAVEERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLAVEERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLAVEERR
    );
endinterface

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: SETUP/ACCESS sequencing, PREADY timeout and response flags.
module apb_master_xfer
    import apb_pwm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  write_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rsp_valid_c_o,
    output logic                  rsp_slverr_c_o,
    output logic                  rsp_timeout_c_o,
    apb_pwm_cfg_sequencer_if.master apb
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            xst_q, xst_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  psel_q, penable_q;

    // A start in the completing ACCESS cycle goes straight to the next SETUP.
    always_comb begin
        xst_d           = xst_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        write_d         = write_q;
        rsp_valid_c_o   = 1'b0;
        rsp_slverr_c_o  = 1'b0;
        rsp_timeout_c_o = 1'b0;
        case (xst_q)
            XF_SETUP: xst_d = XF_ACCESS;
            XF_ACCESS: begin
                if (apb.PREADY) begin
                    rsp_valid_c_o  = 1'b1;
                    rsp_slverr_c_o = apb.PSLAVEERR;
                    xst_d          = XF_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_c_o   = 1'b1;
                    rsp_timeout_c_o = 1'b1;
                    xst_d           = XF_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (start_i) begin
            xst_d   = XF_SETUP;
            cnt_d   = '0;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            write_d = write_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xst_q     <= XF_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            xst_q     <= xst_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            psel_q    <= (xst_d != XF_IDLE);
            penable_q <= (xst_d == XF_ACCESS);
        end
    end

    assign apb.PADDR   = addr_q;
    assign apb.PWDATA  = wdata_q;
    assign apb.PWRITE  = write_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;

endmodule

// File: rtl/apb_pwm_cfg_sequencer.sv
// Programs the APB PWM slave (ENABLE=0, PERIOD, PULSE, SIZE, ENABLE) from one request.
// Define APB_PWM_CFG_READBACK_EN to verify each write with a read of the same register.
module apb_pwm_cfg_sequencer
    import apb_pwm_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH     = 32,
    parameter int unsigned          SIZE_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int unsigned          TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [DATA_WIDTH-1:0] cfg_period_i,
    input  logic [DATA_WIDTH-1:0] cfg_pulse_i,
    input  logic [SIZE_WIDTH-1:0] cfg_size_i,
    input  logic                  cfg_enable_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    apb_pwm_cfg_sequencer_if.master apb
);
    logic [1:0]            state_q, state_d;
    step_t                 step_q, step_d;
    logic [DATA_WIDTH-1:0] period_q, period_d, pulse_q, pulse_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic                  en_q, en_d;
    err_code_e             err_code_q, err_code_d;
    logic                  ready_q, busy_q, done_q, err_q;
    logic                  start_c, xfer_write_c;
    logic [DATA_WIDTH-1:0] xfer_addr_c, xfer_wdata_c;
    logic                  rsp_valid_c, rsp_slverr_c, rsp_timeout_c;

    function automatic logic [DATA_WIDTH-1:0] step_data(step_t s, logic [DATA_WIDTH-1:0] per,
                                                        logic [DATA_WIDTH-1:0] pul,
                                                        logic [SIZE_WIDTH-1:0] sz, logic en);
        case (s)
            3'd1:    return per;
            3'd2:    return pul;
            3'd3:    return DATA_WIDTH'(sz);
            3'd4:    return DATA_WIDTH'(en);
            default: return '0;
        endcase
    endfunction

`ifdef APB_PWM_CFG_READBACK_EN
    logic phase_q, phase_d;
    logic rb_mismatch_c;

    // SIZE is checked on its field width, ENABLE on bit 0, the rest on the full word.
    function automatic logic [DATA_WIDTH-1:0] rb_mask(step_t s);
        case (s)
            3'd0, 3'd4: return DATA_WIDTH'(1);
            3'd3:       return DATA_WIDTH'({SIZE_WIDTH{1'b1}});
            default:    return '1;
        endcase
    endfunction

    assign rb_mismatch_c = |((apb.PRDATA ^ step_data(step_q, period_q, pulse_q, size_q, en_q))
                             & rb_mask(step_q));
`else
    logic unused_prdata;
    assign unused_prdata = ^apb.PRDATA;
`endif

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        period_d     = period_q;
        pulse_d      = pulse_q;
        size_d       = size_q;
        en_d         = en_q;
        err_code_d   = err_code_q;
        start_c      = 1'b0;
        xfer_write_c = 1'b1;
`ifdef APB_PWM_CFG_READBACK_EN
        phase_d      = phase_q;
`endif
        case (state_q)
            SEQ_IDLE: begin
                if (cfg_valid_i) begin
                    period_d   = cfg_period_i;
                    pulse_d    = cfg_pulse_i;
                    size_d     = cfg_size_i;
                    en_d       = cfg_enable_i;
                    err_code_d = ERR_NONE;
                    step_d     = '0;
                    start_c    = 1'b1;
                    state_d    = SEQ_RUN;
`ifdef APB_PWM_CFG_READBACK_EN
                    phase_d    = 1'b0;
`endif
                end
            end
            SEQ_RUN: begin
                if (rsp_valid_c) begin
                    if (rsp_timeout_c) begin
                        err_code_d = ERR_TIMEOUT;
                        state_d    = SEQ_ABORT;
                    end else if (rsp_slverr_c) begin
                        err_code_d = ERR_SLAVE;
                        state_d    = SEQ_ABORT;
`ifdef APB_PWM_CFG_READBACK_EN
                    end else if (!phase_q) begin
                        phase_d      = 1'b1;
                        start_c      = 1'b1;
                        xfer_write_c = 1'b0;
                    end else if (rb_mismatch_c) begin
                        err_code_d = ERR_READBACK;
                        state_d    = SEQ_ABORT;
`endif
                    end else if (step_q == LAST_STEP) begin
                        state_d = SEQ_DONE;
                    end else begin
                        step_d  = step_q + step_t'(1);
                        start_c = 1'b1;
`ifdef APB_PWM_CFG_READBACK_EN
                        phase_d = 1'b0;
`endif
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Address wraps naturally at DATA_WIDTH bits.
    assign xfer_addr_c  = BASE_ADDR + DATA_WIDTH'(step_offset(step_d));
    assign xfer_wdata_c = step_data(step_d, period_d, pulse_d, size_d, en_d);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= SEQ_IDLE;
            step_q     <= '0;
            period_q   <= '0;
            pulse_q    <= '0;
            size_q     <= '0;
            en_q       <= 1'b0;
            err_code_q <= ERR_NONE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef APB_PWM_CFG_READBACK_EN
            phase_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            period_q   <= period_d;
            pulse_q    <= pulse_d;
            size_q     <= size_d;
            en_q       <= en_d;
            err_code_q <= err_code_d;
            ready_q    <= (state_d == SEQ_IDLE);
            busy_q     <= (state_d != SEQ_IDLE);
            done_q     <= (state_d == SEQ_DONE);
            err_q      <= (state_d == SEQ_ABORT);
`ifdef APB_PWM_CFG_READBACK_EN
            phase_q    <= phase_d;
`endif
        end
    end

    apb_master_xfer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .clk_i           (PCLK),
        .rst_i           (PRESET),
        .start_i         (start_c),
        .write_i         (xfer_write_c),
        .addr_i          (xfer_addr_c),
        .wdata_i         (xfer_wdata_c),
        .rsp_valid_c_o   (rsp_valid_c),
        .rsp_slverr_c_o  (rsp_slverr_c),
        .rsp_timeout_c_o (rsp_timeout_c),
        .apb             (apb)
    );

    assign cfg_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule
